// File: rtl/tdc_sequencer.sv
// ============================================================================
// tdc_sequencer : burst controller for the TDC core (arm / wait / abort)
//                 that accumulates sum/min/max and hands back one summary record
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tdc_sequencer #(
  parameter int MEAS_W = 40,
  parameter int CNT_W  = 8,
  parameter int TMO_W  = 28,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [TMO_W-1:0]  timeout_cycles,
  output logic              tdc_arm,
  output logic              tdc_rst_n,
  input  logic [MEAS_W-1:0] tdc_meas,
  input  logic              tdc_meas_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_sum,
  output logic [MEAS_W-1:0] res_min,
  output logic [MEAS_W-1:0] res_max,
  output logic [CNT_W-1:0]  res_count,
  output logic [CNT_W-1:0]  res_timeouts,
  output logic              busy,
  output logic [2:0]        state_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_WAIT    = 3'd2,
    S_ABORT   = 3'd3,
    S_RECOVER = 3'd4,
    S_REPORT  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [TMO_W-1:0]  tmo_lim_q, tmo_lim_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]  attempts_q, attempts_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tmos_q, tmos_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [MEAS_W-1:0] min_q, min_d;
  logic [MEAS_W-1:0] max_q, max_d;
  logic              abort_cnt_q, abort_cnt_d;
  logic              stop_q, stop_d;
  logic              tdc_arm_q, tdc_arm_d;
  logic              tdc_rst_n_q, tdc_rst_n_d;
  logic              res_valid_q, res_valid_d;
  logic [ACC_W-1:0]  res_sum_q, res_sum_d;
  logic [MEAS_W-1:0] res_min_q, res_min_d;
  logic [MEAS_W-1:0] res_max_q, res_max_d;
  logic [CNT_W-1:0]  res_count_q, res_count_d;
  logic [CNT_W-1:0]  res_tmos_q, res_tmos_d;
  logic              busy_q, busy_d;

  logic [CNT_W-1:0]  attempts_inc;
  assign attempts_inc = attempts_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    tmo_lim_d   = tmo_lim_q;
    tmo_cnt_d   = tmo_cnt_q;
    attempts_d  = attempts_q;
    cnt_d       = cnt_q;
    tmos_d      = tmos_q;
    sum_d       = sum_q;
    min_d       = min_q;
    max_d       = max_q;
    abort_cnt_d = 1'b0;
    stop_d      = stop_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_min_d   = res_min_q;
    res_max_d   = res_max_q;
    res_count_d = res_count_q;
    res_tmos_d  = res_tmos_q;

    case (state_q)
      S_IDLE: begin
        if (start && !res_valid_q) begin
          num_d      = num_samples;
          tmo_lim_d  = timeout_cycles;
          sum_d      = '0;
          min_d      = '1;
          max_d      = '0;
          cnt_d      = '0;
          tmos_d     = '0;
          attempts_d = '0;
          stop_d     = 1'b0;
          state_d    = (num_samples == '0) ? S_REPORT : S_ARM;
        end
      end
      S_ARM: begin
        tmo_cnt_d = '0;
        if (stop) begin
          stop_d  = 1'b1;
          state_d = S_ABORT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // stop outranks a same-cycle strobe; strobe outranks a same-cycle timeout
        if (stop) begin
          stop_d  = 1'b1;
          state_d = S_ABORT;
        end else if (tdc_meas_valid) begin
          sum_d      = sum_q + ACC_W'(tdc_meas);
          min_d      = (tdc_meas < min_q) ? tdc_meas : min_q;
          max_d      = (tdc_meas > max_q) ? tdc_meas : max_q;
          cnt_d      = cnt_q + CNT_W'(1);
          attempts_d = attempts_inc;
          state_d    = (attempts_inc < num_q) ? S_ARM : S_REPORT;
        end else if ((tmo_lim_q != '0) && (tmo_cnt_q == tmo_lim_q - TMO_W'(1))) begin
          tmos_d     = tmos_q + CNT_W'(1);
          attempts_d = attempts_inc;
          state_d    = S_ABORT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_ABORT: begin
        if (stop) stop_d = 1'b1;
        if (abort_cnt_q) state_d = S_RECOVER;
        else             abort_cnt_d = 1'b1;
      end
      S_RECOVER: begin
        state_d = (stop_q || stop || (attempts_q >= num_q)) ? S_REPORT : S_ARM;
      end
      S_REPORT: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_sum_d   = sum_q;
          res_min_d   = min_q;
          res_max_d   = max_q;
          res_count_d = cnt_q;
          res_tmos_d  = tmos_q;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Core-facing strobes follow the next state so they line up with it exactly.
    tdc_arm_d   = (state_d == S_ARM);
    tdc_rst_n_d = (state_d != S_ABORT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      tmo_lim_q   <= '0;
      tmo_cnt_q   <= '0;
      attempts_q  <= '0;
      cnt_q       <= '0;
      tmos_q      <= '0;
      sum_q       <= '0;
      min_q       <= '1;
      max_q       <= '0;
      abort_cnt_q <= 1'b0;
      stop_q      <= 1'b0;
      tdc_arm_q   <= 1'b0;
      tdc_rst_n_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_min_q   <= '1;
      res_max_q   <= '0;
      res_count_q <= '0;
      res_tmos_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      tmo_lim_q   <= tmo_lim_d;
      tmo_cnt_q   <= tmo_cnt_d;
      attempts_q  <= attempts_d;
      cnt_q       <= cnt_d;
      tmos_q      <= tmos_d;
      sum_q       <= sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      abort_cnt_q <= abort_cnt_d;
      stop_q      <= stop_d;
      tdc_arm_q   <= tdc_arm_d;
      tdc_rst_n_q <= tdc_rst_n_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_min_q   <= res_min_d;
      res_max_q   <= res_max_d;
      res_count_q <= res_count_d;
      res_tmos_q  <= res_tmos_d;
      busy_q      <= busy_d;
    end
  end

  assign tdc_arm      = tdc_arm_q;
  assign tdc_rst_n    = tdc_rst_n_q;
  assign res_valid    = res_valid_q;
  assign res_sum      = res_sum_q;
  assign res_min      = res_min_q;
  assign res_max      = res_max_q;
  assign res_count    = res_count_q;
  assign res_timeouts = res_tmos_q;
  assign busy         = busy_q;
  assign state_out    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_tdc_sequencer.sv
// ============================================================================
// tb_tdc_sequencer : directed bench for tdc_sequencer
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_tdc_sequencer;

  localparam int MEAS_W = 40;
  localparam int CNT_W  = 8;
  localparam int TMO_W  = 28;
  localparam int ACC_W  = 48;
  localparam logic [63:0] ONES40 = 64'h0000_00FF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [CNT_W-1:0]  num_samples = '0;
  logic [TMO_W-1:0]  timeout_cycles = '0;
  logic              tdc_arm;
  logic              tdc_rst_n;
  logic [MEAS_W-1:0] tdc_meas = '0;
  logic              tdc_meas_valid = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [ACC_W-1:0]  res_sum;
  logic [MEAS_W-1:0] res_min;
  logic [MEAS_W-1:0] res_max;
  logic [CNT_W-1:0]  res_count;
  logic [CNT_W-1:0]  res_timeouts;
  logic              busy;
  logic [2:0]        state_out;

  int total = 0;
  int bad   = 0;
  int arm_seen = 0;
  int rst_seen = 0;
  int arm_mark;
  int rst_mark;

  tdc_sequencer #(.MEAS_W(MEAS_W), .CNT_W(CNT_W), .TMO_W(TMO_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .num_samples(num_samples), .timeout_cycles(timeout_cycles),
    .tdc_arm(tdc_arm), .tdc_rst_n(tdc_rst_n),
    .tdc_meas(tdc_meas), .tdc_meas_valid(tdc_meas_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_min(res_min), .res_max(res_max),
    .res_count(res_count), .res_timeouts(res_timeouts),
    .busy(busy), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Count cycles of arm pulse and core reset, sampled shortly after each edge.
  always @(posedge clk) begin
    #2;
    if (rst_n && tdc_arm) arm_seen++;
    if (rst_n && !tdc_rst_n) rst_seen++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int n, input int t);
    num_samples    = CNT_W'(n);
    timeout_cycles = TMO_W'(t);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input int v);
    tdc_meas       = MEAS_W'(v);
    tdc_meas_valid = 1'b1;
    tick();
    tdc_meas_valid = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("accept_valid_low", 64'(res_valid), 64'd0);
    chk("accept_idle", 64'(state_out), 64'd0);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (3) tick();
    chk("rst_state", 64'(state_out), 64'd0);
    chk("rst_core_rst_n", 64'(tdc_rst_n), 64'd0);
    chk("rst_arm", 64'(tdc_arm), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_min", 64'(res_min), ONES40);
    chk("rst_sum", 64'(res_sum), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_release_core", 64'(tdc_rst_n), 64'd1);

    // ---------------- 4 good measurements ----------------
    arm_mark = arm_seen;
    do_start(4, 1000);
    chk("t1_arm_first", 64'(tdc_arm), 64'd1);
    chk("t1_state_arm", 64'(state_out), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_state_wait", 64'(state_out), 64'd2);
    chk("t1_arm_single", 64'(tdc_arm), 64'd0);
    repeat (3) tick();
    strobe(100);
    chk("t1_rearm", 64'(tdc_arm), 64'd1);
    tick();
    strobe(300);
    tick();
    repeat (7) tick();
    strobe(200);
    tick();
    strobe(400);
    chk("t1_report_state", 64'(state_out), 64'd5);
    chk("t1_valid_not_yet", 64'(res_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_sum", 64'(res_sum), 64'd1000);
    chk("t1_min", 64'(res_min), 64'd100);
    chk("t1_max", 64'(res_max), 64'd400);
    chk("t1_count", 64'(res_count), 64'd4);
    chk("t1_tmo", 64'(res_timeouts), 64'd0);
    chk("t1_arm_pulses", 64'(arm_seen - arm_mark), 64'd4);
    accept();

    // ---------------- timeout, no strobe ----------------
    rst_mark = rst_seen;
    do_start(1, 50);
    tick();
    chk("t2_wait", 64'(state_out), 64'd2);
    repeat (49) tick();
    chk("t2_last_wait", 64'(state_out), 64'd2);
    chk("t2_core_up", 64'(tdc_rst_n), 64'd1);
    tick();
    chk("t2_abort", 64'(state_out), 64'd3);
    chk("t2_core_rst0", 64'(tdc_rst_n), 64'd0);
    tick();
    chk("t2_core_rst1", 64'(tdc_rst_n), 64'd0);
    tick();
    chk("t2_recover", 64'(state_out), 64'd4);
    chk("t2_core_rel", 64'(tdc_rst_n), 64'd1);
    tick();
    chk("t2_report", 64'(state_out), 64'd5);
    tick();
    chk("t2_valid", 64'(res_valid), 64'd1);
    chk("t2_count", 64'(res_count), 64'd0);
    chk("t2_tmo", 64'(res_timeouts), 64'd1);
    chk("t2_min", 64'(res_min), ONES40);
    chk("t2_max", 64'(res_max), 64'd0);
    chk("t2_sum", 64'(res_sum), 64'd0);
    chk("t2_rst_cycles", 64'(rst_seen - rst_mark), 64'd2);
    accept();

    // ---------------- strobe on the timeout cycle ----------------
    rst_mark = rst_seen;
    do_start(1, 50);
    tick();
    repeat (49) tick();
    strobe(77);
    chk("t3_report", 64'(state_out), 64'd5);
    tick();
    chk("t3_valid", 64'(res_valid), 64'd1);
    chk("t3_count", 64'(res_count), 64'd1);
    chk("t3_tmo", 64'(res_timeouts), 64'd0);
    chk("t3_sum", 64'(res_sum), 64'd77);
    chk("t3_min", 64'(res_min), 64'd77);
    chk("t3_max", 64'(res_max), 64'd77);
    chk("t3_no_core_rst", 64'(rst_seen - rst_mark), 64'd0);

    // ---------------- backpressure, start ignored ----------------
    arm_mark = arm_seen;
    repeat (10) tick();
    do_start(3, 0);
    tick();
    chk("t4_valid_held", 64'(res_valid), 64'd1);
    chk("t4_sum_held", 64'(res_sum), 64'd77);
    chk("t4_count_held", 64'(res_count), 64'd1);
    chk("t4_busy", 64'(busy), 64'd1);
    chk("t4_state", 64'(state_out), 64'd5);
    chk("t4_no_arm", 64'(arm_seen - arm_mark), 64'd0);
    accept();

    // ---------------- zero samples ----------------
    arm_mark = arm_seen;
    do_start(0, 100);
    chk("t5_report", 64'(state_out), 64'd5);
    chk("t5_valid_early", 64'(res_valid), 64'd0);
    tick();
    chk("t5_valid", 64'(res_valid), 64'd1);
    chk("t5_count", 64'(res_count), 64'd0);
    chk("t5_tmo", 64'(res_timeouts), 64'd0);
    chk("t5_sum", 64'(res_sum), 64'd0);
    chk("t5_min", 64'(res_min), ONES40);
    chk("t5_max", 64'(res_max), 64'd0);
    chk("t5_no_arm", 64'(arm_seen - arm_mark), 64'd0);
    accept();

    // ---------------- stray strobe in IDLE, then stop mid-WAIT ----------------
    strobe(999);
    do_start(5, 0);
    tick();
    strobe(10);
    tick();
    strobe(20);
    tick();
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_abort", 64'(state_out), 64'd3);
    chk("t6_core_rst", 64'(tdc_rst_n), 64'd0);
    tick();
    tick();
    chk("t6_recover", 64'(state_out), 64'd4);
    tick();
    chk("t6_report", 64'(state_out), 64'd5);
    tick();
    chk("t6_valid", 64'(res_valid), 64'd1);
    chk("t6_count", 64'(res_count), 64'd2);
    chk("t6_sum", 64'(res_sum), 64'd30);
    chk("t6_min", 64'(res_min), 64'd10);
    chk("t6_max", 64'(res_max), 64'd20);
    chk("t6_tmo", 64'(res_timeouts), 64'd0);
    accept();

    // ---------------- reset mid-WAIT ----------------
    do_start(5, 0);
    tick();
    strobe(10);
    tick();
    strobe(20);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t7_state", 64'(state_out), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_core_rst", 64'(tdc_rst_n), 64'd0);
    chk("t7_arm", 64'(tdc_arm), 64'd0);
    chk("t7_valid", 64'(res_valid), 64'd0);
    chk("t7_min", 64'(res_min), ONES40);
    chk("t7_count", 64'(res_count), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("t7_core_rel", 64'(tdc_rst_n), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
